// File: rtl/fas_freq_analyzer.sv
// fas_freq_analyzer: 16-bin FFT peak-power detector (in: clk, rst, fft_valid, fft_d0..fft_d15 as {re,im}; out: done strobe, freq peak bin, overrun strobe)
module fas_freq_analyzer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic        overrun
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;
  logic [2:0] pair_q, pair_d;
  logic [31:0] frame [16];
  logic [31:0] buf_q [16];
  logic [31:0] max_pow_q, max_pow_d, p0, p1, pw, best_pow;
  logic [3:0] max_idx_q, max_idx_d, wi, best_idx, freq_q, freq_d;
  logic done_q, done_d, overrun_q, overrun_d, last, abort, scanning, take;
  function automatic logic [31:0] pow(input logic [31:0] w);
    logic signed [31:0] re, im;
    re = {{16{w[31]}}, w[31:16]};
    im = {{16{w[15]}}, w[15:0]};
    return re * re + im * im;
  endfunction
  assign frame = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                   fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
  assign p0 = pow(buf_q[{pair_q, 1'b0}]);
  assign p1 = pow(buf_q[{pair_q, 1'b1}]);
  assign pw = p1 > p0 ? p1 : p0;
  assign wi = {pair_q, p1 > p0};
  assign take = pair_q == 3'd0 || pw > max_pow_q;
  assign best_pow = take ? pw : max_pow_q;
  assign best_idx = take ? wi : max_idx_q;
  assign last = pair_q == 3'd7;
  assign abort = state_q == SCAN && fft_valid && !last;
  assign scanning = state_q == SCAN && !abort;
  always_comb begin
    state_d = fft_valid ? SCAN : (state_q == SCAN && last) ? IDLE : state_q;
    pair_d = (fft_valid || state_q == IDLE) ? 3'd0 : pair_q + 3'd1;
    max_pow_d = scanning ? best_pow : max_pow_q;
    max_idx_d = scanning ? best_idx : max_idx_q;
    done_d = scanning && last;
    overrun_d = abort;
    freq_d = done_d ? best_idx : freq_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pair_q <= 3'd0;
      max_pow_q <= 32'd0;
      max_idx_q <= 4'd0;
      done_q <= 1'b0;
      overrun_q <= 1'b0;
      freq_q <= 4'd0;
    end else begin
      state_q <= state_d;
      pair_q <= pair_d;
      max_pow_q <= max_pow_d;
      max_idx_q <= max_idx_d;
      done_q <= done_d;
      overrun_q <= overrun_d;
      freq_q <= freq_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fft_valid) buf_q <= frame;
  end
  assign done = done_q;
  assign freq = freq_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_fas_freq_analyzer.sv
// tb_fas_freq_analyzer: table, directed and random checks of fas_freq_analyzer against a peak-bin model
module tb_fas_freq_analyzer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fft_valid = 1'b0;
  logic [31:0] d [16];
  logic done, overrun;
  logic [3:0] freq;
  int tests = 0;
  int fails = 0;
  typedef logic [15:0][31:0] frame_t;
  typedef struct packed {
    frame_t w;
    logic [3:0] f;
  } vec_t;
  vec_t tbl [4];
  logic [31:0] pal [4];
  always #5 clk = ~clk;
  fas_freq_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .overrun(overrun)
  );
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic drive(input logic v, input frame_t w);
    fft_valid = v;
    for (int i = 0; i < 16; i++) d[i] = w[i];
  endtask
  function automatic frame_t one_hot(input int k, input logic [31:0] v);
    frame_t w;
    w = '0;
    w[k] = v;
    return w;
  endfunction
  function automatic logic [3:0] peak(input frame_t w);
    longint best, p, re, im;
    logic [3:0] idx;
    best = -1;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      re = longint'($signed(w[i][31:16]));
      im = longint'($signed(w[i][15:0]));
      p = re * re + im * im;
      if (p > best) begin
        best = p;
        idx = 4'(i);
      end
    end
    return idx;
  endfunction
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, " done low"}, 32'(done), 32'd0);
      chk({tag, " overrun low"}, 32'(overrun), 32'd0);
    end
  endtask
  task automatic run_frame(input frame_t w, input logic [3:0] e, input string tag);
    drive(1'b1, w);
    tick();
    fft_valid = 1'b0;
    quiet(7, tag);
    tick();
    chk({tag, " done at E8"}, 32'(done), 32'd1);
    chk({tag, " freq"}, 32'(freq), 32'(e));
    chk({tag, " overrun at E8"}, 32'(overrun), 32'd0);
    tick();
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask
  initial begin
    frame_t w;
    tbl[0].w = one_hot(1, 32'h0100_0000);
    tbl[0].f = 4'd1;
    for (int i = 0; i < 16; i++) tbl[1].w[i] = 32'h7FFF_0000;
    tbl[1].w[15] = 32'h8000_8000;
    tbl[1].f = 4'd15;
    tbl[2].w = '0;
    tbl[2].w[3] = 32'h0200_FE00;
    tbl[2].w[9] = 32'h0200_FE00;
    tbl[2].w[14] = 32'h0200_FE00;
    tbl[2].f = 4'd3;
    tbl[3].w = '0;
    tbl[3].f = 4'd0;
    pal[0] = 32'h0000_0000;
    pal[1] = 32'h0100_0000;
    pal[2] = 32'hFF00_0000;
    pal[3] = 32'h0000_0100;
    drive(1'b0, '0);
    @(negedge clk);
    tick();
    tick();
    chk("reset done", 32'(done), 32'd0);
    chk("reset freq", 32'(freq), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    quiet(3, "idle");
    for (int i = 0; i < 4; i++) run_frame(tbl[i].w, tbl[i].f, $sformatf("table%0d", i));
    drive(1'b1, one_hot(1, 32'h0100_0000));
    tick();
    fft_valid = 1'b0;
    quiet(7, "b2b A");
    drive(1'b1, one_hot(15, 32'h0100_0000));
    tick();
    chk("b2b A done", 32'(done), 32'd1);
    chk("b2b A freq", 32'(freq), 32'd1);
    chk("b2b A overrun", 32'(overrun), 32'd0);
    fft_valid = 1'b0;
    quiet(7, "b2b B");
    tick();
    chk("b2b B done", 32'(done), 32'd1);
    chk("b2b B freq", 32'(freq), 32'd15);
    chk("b2b B overrun", 32'(overrun), 32'd0);
    tick();
    chk("b2b B done one cycle", 32'(done), 32'd0);
    drive(1'b1, one_hot(1, 32'h0100_0000));
    tick();
    fft_valid = 1'b0;
    quiet(3, "ovr A");
    drive(1'b1, one_hot(7, 32'h0000_0300));
    tick();
    chk("ovr pulse", 32'(overrun), 32'd1);
    chk("ovr no done", 32'(done), 32'd0);
    chk("ovr freq held", 32'(freq), 32'd15);
    fft_valid = 1'b0;
    tick();
    chk("ovr one cycle", 32'(overrun), 32'd0);
    chk("ovr freq held E1", 32'(freq), 32'd15);
    quiet(6, "ovr B");
    chk("ovr freq held E7", 32'(freq), 32'd15);
    tick();
    chk("ovr B done", 32'(done), 32'd1);
    chk("ovr B freq", 32'(freq), 32'd7);
    chk("ovr B no overrun", 32'(overrun), 32'd0);
    drive(1'b1, one_hot(9, 32'h0100_0000));
    tick();
    fft_valid = 1'b0;
    quiet(4, "rst scan");
    rst = 1'b1;
    tick();
    chk("rst done", 32'(done), 32'd0);
    chk("rst freq", 32'(freq), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    quiet(12, "after rst");
    chk("after rst freq", 32'(freq), 32'd0);
    run_frame(one_hot(5, 32'h0000_0100), 4'd5, "post rst");
    rst = 1'b1;
    drive(1'b1, one_hot(6, 32'h0100_0000));
    tick();
    rst = 1'b0;
    fft_valid = 1'b0;
    quiet(10, "rst priority");
    chk("rst priority freq", 32'(freq), 32'd0);
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 16; i++) w[i] = (n % 2 == 1) ? pal[$urandom_range(0, 3)] : $urandom;
      run_frame(w, peak(w), $sformatf("rand%0d", n));
      quiet($urandom_range(0, 3), "rand gap");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
